// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: writeback source selects, load funct3
// codes and the writeback stage register layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    wb_sel_e     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] ld;
  } wb_stage_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of an aligned memory word and extends it
// according to the load type; unknown load types behave as LW.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and sign/zero extension
  always_comb begin
    byte_s = word[7:0];
    half_s = word[15:0];
    result = word;
    case (offset)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LHU:  result = {16'h0000, half_s};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: MEM/WB stage register, result selection, bypass to
// execute and the retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_reg_write,
  input  logic [4:0]  m_rd_index,
  input  logic [1:0]  m_wb_sel,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_pc_plus4,
  input  logic [31:0] m_imm,
  input  logic [31:0] m_ld_data,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_index,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [63:0] instret
);

  wb_stage_t   stage_r;
  wb_stage_t   capture_s;
  logic [63:0] instret_r;
  logic [31:0] ld_aligned_s;
  logic        wb_en_s;
  logic [31:0] wb_data_s;

  assign capture_s = '{valid:     m_valid,
                       reg_write: m_reg_write,
                       rd:        m_rd_index,
                       wb_sel:    wb_sel_e'(m_wb_sel),
                       funct3:    m_funct3,
                       alu:       m_alu_result,
                       pc4:       m_pc_plus4,
                       imm:       m_imm,
                       ld:        m_ld_data};

  // Stage register: flush inserts a bubble and outranks stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else if (flush) begin
      stage_r.valid <= 1'b0;
    end else if (!stall) begin
      stage_r <= capture_s;
    end else begin
      stage_r <= stage_r;
    end
  end

  // Count instructions as they enter writeback, so a stalled one counts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= 64'd0;
    end else if (m_valid && !stall && !flush) begin
      instret_r <= instret_r + 64'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  load_align u_load_align (
    .funct3 (stage_r.funct3),
    .offset (stage_r.alu[1:0]),
    .word   (stage_r.ld),
    .result (ld_aligned_s)
  );

  // Writeback result mux and write enable (x0 is never written)
  always_comb begin
    wb_en_s   = stage_r.valid && stage_r.reg_write && (stage_r.rd != 5'd0);
    wb_data_s = stage_r.alu;
    case (stage_r.wb_sel)
      WB_ALU:  wb_data_s = stage_r.alu;
      WB_LOAD: wb_data_s = ld_aligned_s;
      WB_PC4:  wb_data_s = stage_r.pc4;
      WB_IMM:  wb_data_s = stage_r.imm;
      default: wb_data_s = stage_r.alu;
    endcase
  end

  assign wb_en     = wb_en_s;
  assign wb_data   = wb_data_s;
  assign rd_index  = stage_r.rd;
  assign fwd_valid = wb_en_s;
  assign fwd_rd    = stage_r.rd;
  assign fwd_data  = wb_data_s;
  assign instret   = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed corner cases plus random traffic
// against a behavioural model of the stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, m_valid, m_reg_write;
  logic [4:0]  m_rd_index;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_pc_plus4, m_imm, m_ld_data;
  logic        wb_en, fwd_valid;
  logic [31:0] wb_data, fwd_data;
  logic [4:0]  rd_index, fwd_rd;
  logic [63:0] instret;

  int n_assert = 0;
  int n_fail   = 0;

  // model of what the stage currently holds
  logic        e_valid, e_rw;
  logic [4:0]  e_rd;
  logic [1:0]  e_sel;
  logic [2:0]  e_f3;
  logic [31:0] e_alu, e_pc4, e_imm, e_ld;
  logic [63:0] e_cnt;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd_index(m_rd_index),
    .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_result(m_alu_result),
    .m_pc_plus4(m_pc_plus4), .m_imm(m_imm), .m_ld_data(m_ld_data),
    .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    int b;
    int h;
    case (f3)
      3'd0: begin
        sh = word >> (8 * off);
        b = int'(sh & 32'hFF);
        if (b >= 128) b = b - 256;
        return 32'(b);
      end
      3'd4: return (word >> (8 * off)) & 32'h0000_00FF;
      3'd1: begin
        sh = word >> (16 * off[1]);
        h = int'(sh & 32'hFFFF);
        if (h >= 32768) h = h - 65536;
        return 32'(h);
      end
      3'd5: return (word >> (16 * off[1])) & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_data();
    case (e_sel)
      2'd1:    return ref_load(e_f3, e_alu[1:0], e_ld);
      2'd2:    return e_pc4;
      2'd3:    return e_imm;
      default: return e_alu;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic exp_en;
    exp_en = e_valid && e_rw && (e_rd != 5'd0);
    chk({tag, ".wb_en"},     64'(wb_en),     64'(exp_en));
    chk({tag, ".wb_data"},   64'(wb_data),   64'(ref_data()));
    chk({tag, ".rd_index"},  64'(rd_index),  64'(e_rd));
    chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(exp_en));
    chk({tag, ".fwd_rd"},    64'(fwd_rd),    64'(e_rd));
    chk({tag, ".fwd_data"},  64'(fwd_data),  64'(ref_data()));
    chk({tag, ".instret"},   instret,        e_cnt);
  endtask

  task automatic model_reset();
    e_valid = 1'b0; e_rw = 1'b0; e_rd = 5'd0; e_sel = 2'd0; e_f3 = 3'd0;
    e_alu = 32'd0; e_pc4 = 32'd0; e_imm = 32'd0; e_ld = 32'd0; e_cnt = 64'd0;
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] imm, input logic [31:0] ld);
    m_valid = v; m_reg_write = rw; m_rd_index = rd; m_wb_sel = sel; m_funct3 = f3;
    m_alu_result = alu; m_pc_plus4 = pc4; m_imm = imm; m_ld_data = ld;
  endtask

  // one clock: model follows the stage rules at the edge, outputs checked at negedge
  task automatic tick(input string tag);
    @(posedge clk);
    if (flush) begin
      e_valid = 1'b0;
    end else if (!stall) begin
      e_valid = m_valid; e_rw = m_reg_write; e_rd = m_rd_index; e_sel = m_wb_sel;
      e_f3 = m_funct3; e_alu = m_alu_result; e_pc4 = m_pc_plus4; e_imm = m_imm; e_ld = m_ld_data;
      if (m_valid) e_cnt = e_cnt + 64'd1;
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h1234_5678, 32'h4, 32'h8, 32'hFFFF_FFFF);
    model_reset();
    #2;
    chk_all("reset");
    @(negedge clk);
    chk_all("reset_clk");
    rst_n = 1'b1;

    // LB / LBU, byte 3 of 0x80FF7F01
    set_in(1'b1, 1'b1, 5'd5, 2'd1, 3'b000, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01);
    tick("lb");
    chk("lb_const", 64'(wb_data), 64'h0000_0000_FFFF_FF80);
    set_in(1'b1, 1'b1, 5'd5, 2'd1, 3'b100, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01);
    tick("lbu");
    chk("lbu_const", 64'(wb_data), 64'h0000_0000_0000_0080);

    // LH offset 3 (upper half), LHU offset 0
    set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b001, 32'h0000_2003, 32'h0, 32'h0, 32'h8001_1234);
    tick("lh");
    chk("lh_const", 64'(wb_data), 64'h0000_0000_FFFF_8001);
    set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b101, 32'h0000_2000, 32'h0, 32'h0, 32'h8001_1234);
    tick("lhu");
    chk("lhu_const", 64'(wb_data), 64'h0000_0000_0000_1234);

    // write to x0 is suppressed but still retires
    set_in(1'b1, 1'b1, 5'd0, 2'd0, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    tick("x0");
    chk("x0_wb_en", 64'(wb_en), 64'd0);
    chk("x0_instret", instret, 64'd5);

    // JAL rd=1 held by a 3-cycle stall
    set_in(1'b1, 1'b1, 5'd1, 2'd2, 3'b000, 32'h0, 32'h0000_0104, 32'h0, 32'h0);
    tick("jal");
    stall = 1'b1;
    set_in(1'b1, 1'b1, 5'd9, 2'd0, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_en", 64'(wb_en), 64'd1);
      chk("stall_data", 64'(wb_data), 64'h0000_0000_0000_0104);
    end
    chk("stall_instret", instret, 64'd6);

    // stall and flush together: bubble, no count
    flush = 1'b1;
    tick("stall_flush");
    chk("sf_wb_en", 64'(wb_en), 64'd0);
    chk("sf_instret", instret, 64'd6);
    stall = 1'b0; flush = 1'b0;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_in(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
             $urandom, $urandom, $urandom, $urandom);
      tick("rand");
    end
    stall = 1'b0; flush = 1'b0;

    // counter wrap from all-ones
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_r;
    e_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    set_in(1'b1, 1'b1, 5'd3, 2'd3, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0);
    tick("wrap");
    chk("wrap_const", instret, 64'd0);
    tick("post_wrap");

    // asynchronous reset mid-cycle while stalled
    stall = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    chk("async_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    set_in(1'b1, 1'b1, 5'd4, 2'd0, 3'b000, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0);
    tick("after_rst");
    chk("after_rst_instret", instret, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: stall  input  1  hold the stage register.
REQ-004 SHALL have ports: flush  input  1  load a bubble into the stage register.
REQ-005 SHALL have ports: m_valid  input  1  the MEM stage holds a real instruction.
REQ-006 SHALL have ports: m_reg_write  input  1  the instruction writes rd.
REQ-007 SHALL have ports: m_rd_index  input  5  destination register.
REQ-008 SHALL have ports: m_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-009 SHALL have ports: m_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 SHALL have ports: m_alu_result, m_pc_plus4, m_imm, m_ld_data  input  32 each  datapath operands; m_ld_data is the raw aligned memory word.
REQ-011 SHALL have ports: wb_en  output  1; wb_data  output  32; rd_index  output  5  register-file write port.
REQ-012 SHALL have ports: fwd_valid  output  1; fwd_rd  output  5; fwd_data  output  32  bypass to the execute stage.
REQ-013 SHALL have ports: instret  output  64  count of retired instructions.

Function
REQ-014 SHALL capture all m_* inputs into the stage register on a rising clk when stall=0 and flush=0; latency from MEM to the writeback outputs is 1 cycle.
REQ-015 SHALL clear valid_q on a rising clk when flush=1, regardless of stall; flush has priority over stall.
REQ-016 SHALL hold every stage-register field when stall=1 and flush=0.
REQ-017 SHALL drive wb_en = valid_q AND reg_write_q AND (rd_q != 0); rd_index = rd_q.
REQ-018 SHALL select wb_data per wb_sel_q: ALU result, aligned load data, PC+4, or immediate.
REQ-019 SHALL align loads using alu_q[1:0]: LB/LBU select byte alu_q[1:0]; LH/LHU select halfword alu_q[1] and ignore alu_q[0]; LW ignores alu_q[1:0].
REQ-020 SHALL sign-extend LB/LH from bit 7/15, zero-extend LBU/LHU, and treat undefined funct3 values (011, 110, 111) as LW.
REQ-021 SHALL drive fwd_valid = wb_en, fwd_rd = rd_q, fwd_data = wb_data, all combinational from the stage register.
REQ-022 SHALL increment instret by 1 on each rising clk that captures m_valid=1 with stall=0 and flush=0; instret wraps from 2^64-1 to 0.
REQ-023 SHALL keep wb_en asserted with unchanged data for the full duration of a stall; the repeated register-file write is legal.

Reset
REQ-024 SHALL, while rst_n=0, force valid_q=0, all data fields to 0, and instret to 0 immediately, without waiting for clk.
REQ-025 SHALL, as a consequence of REQ-024, drive wb_en=0, fwd_valid=0, wb_data=0, and rd_index=0 during reset.
REQ-026 SHALL begin capturing on the first rising clk after rst_n deasserts; asserting reset during a stall discards the held instruction and leaves it uncounted.

Structure
REQ-027 SHALL take the wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4, WB_IMM) and the load funct3 constants from a shared package, riscv_pkg.
REQ-028 SHALL implement byte/halfword selection and extension in one sub-module, load_align (inputs: funct3, offset[1:0], word; output: 32-bit result).
REQ-029 SHALL contain no storage other than the stage register and instret.

Verification
REQ-030 SHALL cover: LB with m_ld_data=32'h80FF_7F01, alu[1:0]=3 -> wb_data=32'hFFFF_FF80 one cycle later; the same stimulus with LBU -> 32'h0000_0080.
REQ-031 SHALL cover: LH with m_ld_data=32'h8001_1234, alu[1:0]=2'b11 -> 32'hFFFF_8001; LHU with offset 0 -> 32'h0000_1234.
REQ-032 SHALL cover: m_reg_write=1, rd=0, ALU result 32'hDEAD_BEEF -> wb_en=0, fwd_valid=0, instret still increments.
REQ-033 SHALL cover: stall=1 for 3 cycles holding JAL rd=1 with PC+4=32'h0000_0104 -> wb_en=1 and wb_data=32'h104 throughout; instret +1 total.
REQ-034 SHALL cover: stall=1 and flush=1 in the same cycle -> valid_q=0 next cycle, wb_en=0, instret unchanged.
REQ-035 SHALL cover: instret preset near 2^64-1 via a stream of valid instructions or a forced value -> wraps to 0; rst_n pulsed low mid-cycle -> all outputs 0 asynchronously.
